// File: rtl/dsp_pipe_mux_if.sv
// Operand bus for dsp_pipe_mux: control, per-channel operands, select and
// the selected/pipelined results travelling back to the consumer.
interface dsp_pipe_mux_if #(
  parameter int WIDTH  = 18,
  parameter int NUM_CH = 2
);
  logic                    ce;
  logic                    sclr;
  logic                    in_valid;
  logic [NUM_CH-1:0]       sel;
  logic [NUM_CH*WIDTH-1:0] in_direct;
  logic [NUM_CH*WIDTH-1:0] in_cascade;
  logic [NUM_CH*WIDTH-1:0] cas_out;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_src;
  logic                    out_valid;
  logic                    pipe_busy;

  modport master (
    output ce, sclr, in_valid, sel, in_direct, in_cascade,
    input  cas_out, out_data, out_src, out_valid, pipe_busy
  );

  modport slave (
    input  ce, sclr, in_valid, sel, in_direct, in_cascade,
    output cas_out, out_data, out_src, out_valid, pipe_busy
  );
endinterface

// File: rtl/dsp_pipe_mux.sv
// Per-channel direct/cascade operand select followed by a 0-4 stage register
// pipeline; every stage carries a valid bit and the source tag of its entry.
module dsp_pipe_mux #(
  parameter int    WIDTH    = 18,
  parameter int    NUM_CH   = 2,
  parameter int    DEPTH    = 1,
  parameter string SEL_MODE = "RUNTIME"
) (
  input  logic          clk,
  input  logic          rst_n,
  dsp_pipe_mux_if.slave bus
);
  localparam int DW   = NUM_CH * WIDTH;
  localparam int MODE = (SEL_MODE == "DIRECT")  ? 0 :
                        (SEL_MODE == "CASCADE") ? 1 :
                        (SEL_MODE == "RUNTIME") ? 2 : 3;

  logic [NUM_CH-1:0] sel_eff_s;
  logic [DW-1:0]     cas_s;

  // Bad parameters instantiate a module that does not exist, stopping elaboration.
  generate
    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
      dsp_pipe_mux_illegal_depth u_bad ();
    end

    case (MODE)
      0: begin : g_direct
        assign sel_eff_s = '0;
      end
      1: begin : g_cascade
        assign sel_eff_s = '1;
      end
      2: begin : g_runtime
        assign sel_eff_s = bus.sel;
      end
      default: begin : g_bad_mode
        dsp_pipe_mux_illegal_sel_mode u_bad ();
        assign sel_eff_s = '0;
      end
    endcase
  endgenerate

  // Channel mux: cascade operand where the effective select bit is set.
  always_comb begin
    cas_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_eff_s[k]) begin
        cas_s[k*WIDTH +: WIDTH] = bus.in_cascade[k*WIDTH +: WIDTH];
      end else begin
        cas_s[k*WIDTH +: WIDTH] = bus.in_direct[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.cas_out = cas_s;

  generate
    if (DEPTH == 0) begin : g_passthru
      assign bus.out_data  = cas_s;
      assign bus.out_src   = sel_eff_s;
      assign bus.out_valid = bus.in_valid;
      assign bus.pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [DW-1:0]     data_r [DEPTH];
      logic [NUM_CH-1:0] src_r  [DEPTH];
      logic [DEPTH-1:0]  vld_r;

      // Stage shift register: sclr beats ce; data and tag load even when invalid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= '0;
            src_r[i]  <= '0;
          end
          vld_r <= '0;
        end else if (bus.sclr) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= '0;
            src_r[i]  <= '0;
          end
          vld_r <= '0;
        end else if (bus.ce) begin
          data_r[0] <= cas_s;
          src_r[0]  <= sel_eff_s;
          vld_r[0]  <= bus.in_valid;
          for (int i = 1; i < DEPTH; i++) begin
            data_r[i] <= data_r[i-1];
            src_r[i]  <= src_r[i-1];
            vld_r[i]  <= vld_r[i-1];
          end
        end
      end

      assign bus.out_data  = data_r[DEPTH-1];
      assign bus.out_src   = src_r[DEPTH-1];
      assign bus.out_valid = vld_r[DEPTH-1];
      assign bus.pipe_busy = |vld_r;
    end
  endgenerate
endmodule

// File: tb/tb_dsp_pipe_mux.sv
// Bench for dsp_pipe_mux: RUNTIME pipes of depth 2/3/4 against a queue model,
// plus DEPTH=0 CASCADE and DIRECT instances checked combinationally.
module tb_dsp_pipe_mux;
  localparam int W  = 18;
  localparam int NC = 2;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce, sclr, in_valid;
  logic [1:0]    sel;
  logic [DW-1:0] in_direct, in_cascade;

  logic [DW-1:0] od [3];
  logic [DW-1:0] oc [3];
  logic [1:0]    os [3];
  logic          ov [3];
  logic          ob [3];

  logic [DW-1:0] c_od, c_cas, r_od, r_cas;
  logic [1:0]    c_os, r_os;
  logic          c_ov, c_ob, r_ov, r_ob;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_pipe
      dsp_pipe_mux_if #(.WIDTH(W), .NUM_CH(NC)) bus ();
      assign bus.ce         = ce;
      assign bus.sclr       = sclr;
      assign bus.in_valid   = in_valid;
      assign bus.sel        = sel;
      assign bus.in_direct  = in_direct;
      assign bus.in_cascade = in_cascade;
      assign od[g] = bus.out_data;
      assign oc[g] = bus.cas_out;
      assign os[g] = bus.out_src;
      assign ov[g] = bus.out_valid;
      assign ob[g] = bus.pipe_busy;
      dsp_pipe_mux #(.WIDTH(W), .NUM_CH(NC), .DEPTH(g + 2), .SEL_MODE("RUNTIME")) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
      );
    end
  endgenerate

  dsp_pipe_mux_if #(.WIDTH(W), .NUM_CH(NC)) bus_c ();
  assign bus_c.ce = ce;  assign bus_c.sclr = sclr;  assign bus_c.in_valid = in_valid;
  assign bus_c.sel = sel;  assign bus_c.in_direct = in_direct;  assign bus_c.in_cascade = in_cascade;
  assign c_od = bus_c.out_data;  assign c_cas = bus_c.cas_out;  assign c_os = bus_c.out_src;
  assign c_ov = bus_c.out_valid;  assign c_ob = bus_c.pipe_busy;
  dsp_pipe_mux #(.WIDTH(W), .NUM_CH(NC), .DEPTH(0), .SEL_MODE("CASCADE")) u_casc (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  dsp_pipe_mux_if #(.WIDTH(W), .NUM_CH(NC)) bus_r ();
  assign bus_r.ce = ce;  assign bus_r.sclr = sclr;  assign bus_r.in_valid = in_valid;
  assign bus_r.sel = sel;  assign bus_r.in_direct = in_direct;  assign bus_r.in_cascade = in_cascade;
  assign r_od = bus_r.out_data;  assign r_cas = bus_r.cas_out;  assign r_os = bus_r.out_src;
  assign r_ov = bus_r.out_valid;  assign r_ob = bus_r.pipe_busy;
  dsp_pipe_mux #(.WIDTH(W), .NUM_CH(NC), .DEPTH(0), .SEL_MODE("DIRECT")) u_dir (
    .clk(clk), .rst_n(rst_n), .bus(bus_r)
  );

  // Reference model: each pipe is a fixed-length FIFO of entries, oldest at [0].
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    src;
    logic          vld;
  } ent_t;

  ent_t mq [3][$];

  typedef struct {
    logic          ce, sclr, vld;
    logic [1:0]    sel;
    logic [DW-1:0] dir, cas, x_cas, x_data;
    logic [1:0]    x_src;
    logic          x_vld, x_busy;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic ent_t ref_entry();
    ent_t e;
    e.src = sel;
    e.vld = in_valid;
    e.data = '0;
    for (int k = 0; k < NC; k++)
      e.data[k*W +: W] = sel[k] ? in_cascade[k*W +: W] : in_direct[k*W +: W];
    return e;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 3; m++) begin
      mq[m].delete();
      for (int j = 0; j < m + 2; j++) mq[m].push_back('0);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    ent_t drop;
    e = ref_entry();
    if (sclr) model_clear();
    else if (ce) begin
      for (int m = 0; m < 3; m++) begin
        mq[m].push_back(e);
        drop = mq[m].pop_front();
      end
    end
  endtask

  task automatic check_comb();
    ent_t e;
    e = ref_entry();
    for (int m = 0; m < 3; m++) chk($sformatf("d%0d cas_out", m + 2), oc[m], e.data);
    chk("cascade0 data",  c_od,  in_cascade);
    chk("cascade0 cas",   c_cas, in_cascade);
    chk("cascade0 src",   c_os,  2'b11);
    chk("cascade0 valid", c_ov,  in_valid);
    chk("cascade0 busy",  c_ob,  1'b0);
    chk("direct0 data",   r_od,  in_direct);
    chk("direct0 cas",    r_cas, in_direct);
    chk("direct0 src",    r_os,  2'b00);
    chk("direct0 valid",  r_ov,  in_valid);
    chk("direct0 busy",   r_ob,  1'b0);
  endtask

  task automatic check_models();
    logic b;
    for (int m = 0; m < 3; m++) begin
      b = 1'b0;
      for (int j = 0; j < mq[m].size(); j++) b = b | mq[m][j].vld;
      chk($sformatf("d%0d out_data", m + 2),  od[m], mq[m][0].data);
      chk($sformatf("d%0d out_src", m + 2),   os[m], mq[m][0].src);
      chk($sformatf("d%0d out_valid", m + 2), ov[m], mq[m][0].vld);
      chk($sformatf("d%0d pipe_busy", m + 2), ob[m], b);
    end
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_models();
  endtask

  task automatic idle();
    ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; sel = 2'b00;
    in_direct = '0; in_cascade = '0;
  endtask

  task automatic rand_in();
    logic [63:0] r;
    in_valid = 1'($urandom_range(0, 1));
    sel = 2'($urandom_range(0, 3));
    r = {$urandom(), $urandom()};  in_direct  = r[DW-1:0];
    r = {$urandom(), $urandom()};  in_cascade = r[DW-1:0];
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("d%0d async data", m + 2),  od[m], 36'h0);
      chk($sformatf("d%0d async src", m + 2),   os[m], 2'b00);
      chk($sformatf("d%0d async valid", m + 2), ov[m], 1'b0);
      chk($sformatf("d%0d async busy", m + 2),  ob[m], 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    repeat (5) step();
  endtask

  function automatic vec_t mkv(input logic c, input logic s, input logic vl, input logic [1:0] sl,
                               input logic [DW-1:0] d, input logic [DW-1:0] cs,
                               input logic [DW-1:0] xc, input logic [DW-1:0] xd,
                               input logic [1:0] xs, input logic xv, input logic xb);
    vec_t v;
    v.ce = c; v.sclr = s; v.vld = vl; v.sel = sl; v.dir = d; v.cas = cs;
    v.x_cas = xc; v.x_data = xd; v.x_src = xs; v.x_vld = xv; v.x_busy = xb;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] z, ab, abc, p1, p2, m01, m10, x1, x2;
    z   = 36'h0;
    ab  = {18'h00A, 18'h00B};  abc = {18'h0AA, 18'h0BB};
    p1  = {18'h111, 18'h111};  p2  = {18'h222, 18'h222};
    m01 = {18'h111, 18'h222};  m10 = {18'h222, 18'h111};
    x1  = {18'h123, 18'h456};  x2  = {18'h0AB, 18'h0CD};

    // Expectations for the DEPTH=3 pipe, values seen after each step's edge.
    tbl[0]  = mkv(1'b1, 1'b0, 1'b1, 2'b00, ab, abc, ab,  z,   2'b00, 1'b0, 1'b1);
    tbl[1]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b1);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   ab,  2'b00, 1'b1, 1'b1);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b1, 2'b01, p1, p2,  m01, z,   2'b00, 1'b0, 1'b1);
    tbl[4]  = mkv(1'b1, 1'b0, 1'b1, 2'b10, p1, p2,  m10, z,   2'b00, 1'b0, 1'b1);
    tbl[5]  = mkv(1'b1, 1'b0, 1'b1, 2'b11, p1, p2,  p2,  m01, 2'b01, 1'b1, 1'b1);
    tbl[6]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   m10, 2'b10, 1'b1, 1'b1);
    tbl[7]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   p2,  2'b11, 1'b1, 1'b1);
    tbl[8]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[9]  = mkv(1'b1, 1'b1, 1'b1, 2'b00, x1, z,   x1,  z,   2'b00, 1'b0, 1'b0);
    tbl[10] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[11] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[13] = mkv(1'b0, 1'b0, 1'b1, 2'b00, x2, z,   x2,  z,   2'b00, 1'b0, 1'b0);
    tbl[14] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[15] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);
    tbl[16] = mkv(1'b1, 1'b0, 1'b0, 2'b00, z,  z,   z,   z,   2'b00, 1'b0, 1'b0);

    // Reset with idle inputs for three cycles.
    rst_n = 1'b0;
    idle();
    model_clear();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_models();
    end
    rst_n = 1'b1;

    // Directed table: latency, per-entry tagging, sclr with in_valid, ce-low drop.
    for (int i = 0; i < 17; i++) begin
      ce = tbl[i].ce; sclr = tbl[i].sclr; in_valid = tbl[i].vld; sel = tbl[i].sel;
      in_direct = tbl[i].dir; in_cascade = tbl[i].cas;
      step();
      chk($sformatf("tbl%0d cas_out", i),   oc[1], tbl[i].x_cas);
      chk($sformatf("tbl%0d out_data", i),  od[1], tbl[i].x_data);
      chk($sformatf("tbl%0d out_src", i),   os[1], tbl[i].x_src);
      chk($sformatf("tbl%0d out_valid", i), ov[1], tbl[i].x_vld);
      chk($sformatf("tbl%0d pipe_busy", i), ob[1], tbl[i].x_busy);
    end

    // Stall on the DEPTH=2 pipe with two entries inside.
    idle(); in_valid = 1'b1; in_direct = {18'h1, 18'h2};
    step();
    sel = 2'b11; in_cascade = {18'h3, 18'h4};
    step();
    chk("stall pre data", od[0], {18'h1, 18'h2});
    chk("stall pre valid", ov[0], 1'b1);
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step();
      chk($sformatf("stall%0d data", i),  od[0], {18'h1, 18'h2});
      chk($sformatf("stall%0d src", i),   os[0], 2'b00);
      chk($sformatf("stall%0d valid", i), ov[0], 1'b1);
      chk($sformatf("stall%0d busy", i),  ob[0], 1'b1);
    end
    ce = 1'b1; in_valid = 1'b1; sel = 2'b01;
    in_direct = {18'h5, 18'h6}; in_cascade = {18'h7, 18'h8};
    step();
    chk("stall e2 data", od[0], {18'h3, 18'h4});
    chk("stall e2 src", os[0], 2'b11);
    chk("stall e2 valid", ov[0], 1'b1);
    idle();
    step();
    chk("stall e3 data", od[0], {18'h5, 18'h8});
    chk("stall e3 src", os[0], 2'b01);
    chk("stall e3 valid", ov[0], 1'b1);
    step();
    chk("stall drain valid", ov[0], 1'b0);
    step();
    chk("stall drain busy", ob[0], 1'b0);

    // Fill the DEPTH=4 pipe, then sclr while ce is low.
    for (int i = 0; i < 4; i++) begin
      rand_in(); ce = 1'b1; in_valid = 1'b1;
      step();
    end
    chk("clr full busy", ob[2], 1'b1);
    chk("clr full valid", ov[2], 1'b1);
    ce = 1'b0; sclr = 1'b1; in_valid = 1'b1;
    step();
    chk("clr data", od[2], 36'h0);
    chk("clr valid", ov[2], 1'b0);
    chk("clr busy", ob[2], 1'b0);
    idle();
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("clr after%0d valid", i), ov[2], 1'b0);
    end

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      rand_in(); ce = 1'b1; in_valid = 1'b1;
      step();
    end
    async_reset();

    // Randomised traffic against the model, with an occasional async reset.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      ce   = ($urandom_range(0, 9) != 0);
      sclr = ($urandom_range(0, 29) == 0);
      step();
      if (i % 137 == 136) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dsp_pipe_mux.md
# dsp_pipe_mux

Parametrised multi-channel input-select and pipeline stage for the DSP slice datapath. Each channel picks either its direct or its cascade operand, fixed at elaboration or switched at run time, then carries it through a configurable 0–4-deep register pipeline. Each stage holds a valid bit and a source tag. It replaces the fixed single-channel select wherever an operand needs to be both selected and registered, such as the A/B/D operand paths and the cascade chain.

## Interface
- WIDTH, 18, data width per channel
- NUM_CH, 2, number of independent channels
- DEPTH, 1, pipeline stages, legal range 0–4; 0 = combinational pass-through
- SEL_MODE, "RUNTIME", one of "DIRECT", "CASCADE", "RUNTIME"; the first two ignore `sel`
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  clock enable; all stages advance only when high
- sclr  input  1  synchronous clear of all stages; overrides `ce`
- in_valid  input  1  qualifies `in_direct` and `in_cascade` this cycle
- sel  input  NUM_CH  per-channel source select: 1 = cascade, 0 = direct (RUNTIME only)
- in_direct  input  NUM_CH*WIDTH  direct operands, channel k at bits [k*WIDTH +: WIDTH]
- in_cascade  input  NUM_CH*WIDTH  cascade operands, same packing
- cas_out  output  NUM_CH*WIDTH  selected operand before any register, for the next slice
- out_data  output  NUM_CH*WIDTH  pipelined selected operand
- out_src  output  NUM_CH  source tag travelling with `out_data`: 1 = cascade
- out_valid  output  1  `out_data` valid
- pipe_busy  output  1  high if any stage holds a valid entry

## Operation
- Select per channel k:
  - effective select = `sel[k]` (RUNTIME), 0 (DIRECT) or 1 (CASCADE).
  - `cas_out[k]` = `in_cascade[k]` if the effective select is 1, else `in_direct[k]`.
  - `cas_out` is purely combinational.
- Stage 0 captures `cas_out`, the effective select vector and `in_valid`. Stage i captures stage i-1.
- The last stage drives `out_data`, `out_src` and `out_valid`.
- Data and tag registers load on every `ce` edge, whether or not the entry is valid. Only the valid bit qualifies them.
- Priority at each rising edge:
  1. `sclr`: every stage data, tag and valid bit set to 0, regardless of `ce`.
  2. `ce` = 1: all stages shift by one.
  3. `ce` = 0: all stages hold. `in_valid` is ignored and that entry is lost.
- DEPTH = 0:
  - `out_data` = `cas_out`, `out_src` = effective select, `out_valid` = `in_valid`.
  - `pipe_busy` = 0.
  - `ce` and `sclr` have no effect.
- `pipe_busy` = OR of all stage valid bits.
- Illegal DEPTH (>4) or unknown SEL_MODE must fail elaboration, via an undefined-module instance in a generate branch.

## Timing
- Reset: asynchronous on `rst_n` low, released synchronously by the user.
  - `out_data` = 0, `out_src` = 0, `out_valid` = 0, `pipe_busy` = 0.
  - All internal stages are cleared.
- Latency: exactly DEPTH `ce`-high rising edges from the input to `out_data` and `out_valid`.
  - With `ce` held high, an input at edge n appears after edge n+DEPTH-1, i.e. it is visible during cycle n+DEPTH.
- Throughput: one entry per `ce`-high cycle. There is no backpressure; the consumer must accept or drop.
- A `sel` change takes effect on the first edge after it changes. Entries already in the pipe keep their captured tag, so mixed-source streams stay correctly tagged.
- `sclr` together with `in_valid`: the input is discarded and the pipe is empty afterwards.
- `rst_n` asserted mid-stream: all outputs go to 0 immediately. No entry reappears after release.
- A `ce` low period of any length stalls without loss or duplication of entries already in the pipe.

## Test plan
- Reset and idle: `rst_n` = 0 for 3 cycles, then 1, with DEPTH = 2 and inputs idle → `out_data` = 0, `out_valid` = 0 and `pipe_busy` = 0 throughout.
- Latency (DEPTH = 3, RUNTIME, NUM_CH = 2, `ce` = 1): drive `in_direct` = {18'h00A, 18'h00B} with `sel` = 2'b00 and `in_valid` = 1 for 1 cycle at edge 0 → `out_data` = {00A, 00B}, `out_valid` = 1 and `out_src` = 00 after edge 2 only. `cas_out` = {00A, 00B} in the same cycle as the input.
- Per-entry tagging: back-to-back inputs with `sel` = 2'b01, then 2'b10, then 2'b11, direct = 0x111 and cascade = 0x222 → consecutive outputs {0x111, 0x222}/01, {0x222, 0x111}/10, {0x222, 0x222}/11.
- Stall: DEPTH = 2, with 3 valid entries streaming and `ce` = 0 for 4 cycles in the middle → no output change during the stall. The entries then emerge in order with no duplicates, and `pipe_busy` stays 1 throughout the stall.
- Clear priority: with the pipe full (DEPTH = 4) and `ce` = 0, assert `sclr` for 1 cycle → `out_valid` = 0, `out_data` = 0 and `pipe_busy` = 0 on the next edge. Then `ce` = 1 with `in_valid` = 0 → nothing ever emerges.
- Fixed modes: SEL_MODE = "CASCADE", DEPTH = 0, with `sel` toggling randomly → `out_data` always equals `in_cascade` combinationally and `out_src` = all ones. Repeat with "DIRECT" → equals `in_direct` and `out_src` = 0.
